// File: rtl/dispatch_queue.sv
// In-order rename-to-issue FIFO with 8-bit sequence tagging; head shown combinationally, one cycle enqueue-to-visible.
// Backpressure: in_ready drops when full (no same-cycle bypass); flush/rst discard all buffered entries.
module dispatch_queue #(
    parameter int DEPTH  = 8,
    parameter int PHYS_W = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [PHYS_W-1:0]          in_src1,
    input  logic [PHYS_W-1:0]          in_src2,
    input  logic [PHYS_W-1:0]          in_dest,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [PHYS_W-1:0]          out_src1,
    output logic [PHYS_W-1:0]          out_src2,
    output logic [PHYS_W-1:0]          out_dest,
    output logic [7:0]                 out_seq,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [31:0]       instr;
        logic [PHYS_W-1:0] src1;
        logic [PHYS_W-1:0] src2;
        logic [PHYS_W-1:0] dest;
        logic [7:0]        seq;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    seq_q;
    logic          enq, deq;
    entry_t        head;

    assign in_ready  = (count_q < FULL);
    assign out_valid = (count_q != '0);
    assign enq       = in_valid && in_ready && !flush;
    assign deq       = out_valid && out_ready && !flush;

    always_comb begin
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            // seq_q survives a flush so tags stay monotonic across pipeline restarts
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) begin
                mem_q[wr_ptr_q] <= '{instr: in_instr, src1: in_src1, src2: in_src2,
                                     dest: in_dest, seq: seq_q};
                wr_ptr_q <= wr_ptr_q + 1'b1;
                seq_q    <= seq_q + 1'b1;
            end
            if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_instr = head.instr;
    assign out_src1  = head.src1;
    assign out_src2  = head.src2;
    assign out_dest  = head.dest;
    assign out_seq   = head.seq;
    assign count     = count_q;
endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: directed phases plus random traffic against a queue-based reference model.
module tb_dispatch_queue;
    localparam int DEPTH  = 8;
    localparam int PHYS_W = 6;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, out_ready;
    logic              in_ready, out_valid;
    logic [31:0]       in_instr, out_instr;
    logic [PHYS_W-1:0] in_src1, in_src2, in_dest, out_src1, out_src2, out_dest;
    logic [7:0]        out_seq;
    logic [3:0]        count;

    dispatch_queue #(.DEPTH(DEPTH), .PHYS_W(PHYS_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_src1(out_src1), .out_src2(out_src2), .out_dest(out_dest),
        .out_seq(out_seq), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       instr;
        logic [PHYS_W-1:0] s1, s2, d;
        logic [7:0]        seq;
    } ent_t;

    ent_t mq[$];
    int   mseq;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [PHYS_W-1:0] a,
                         input logic [PHYS_W-1:0] b, input logic [PHYS_W-1:0] d,
                         input logic ordy, input logic fl);
        in_valid = v; in_instr = ins; in_src1 = a; in_src2 = b; in_dest = d;
        out_ready = ordy; flush = fl;
    endtask

    task automatic drive_rand(input logic v, input logic ordy, input logic fl);
        drive(v, $urandom, PHYS_W'($urandom), PHYS_W'($urandom), PHYS_W'($urandom), ordy, fl);
    endtask

    // Check current outputs against the model, clock once, then advance the model.
    task automatic step();
        bit   enq, deq;
        ent_t e;
        check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check("count", 32'(count), 32'(mq.size()));
        if (mq.size() != 0) begin
            check("out_instr", out_instr, mq[0].instr);
            check("out_src1", 32'(out_src1), 32'(mq[0].s1));
            check("out_src2", 32'(out_src2), 32'(mq[0].s2));
            check("out_dest", 32'(out_dest), 32'(mq[0].d));
            check("out_seq", 32'(out_seq), 32'(mq[0].seq));
        end
        enq = in_valid && (mq.size() < DEPTH) && !flush;
        deq = out_ready && (mq.size() != 0) && !flush;
        e = '{instr: in_instr, s1: in_src1, s2: in_src2, d: in_dest, seq: 8'(mseq)};
        @(posedge clk); #1;
        if (rst) begin
            mq.delete(); mseq = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (deq) void'(mq.pop_front());
            if (enq) begin
                mq.push_back(e);
                mseq = (mseq + 1) % 256;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, '0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete(); mseq = 0;

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_seq", 32'(out_seq), 32'd0);
        check("rst_out_src", 32'({out_src1, out_src2, out_dest}), 32'd0);

        // ordered pass-through
        drive(1'b1, 32'h11, 6'd1, 6'd0, 6'd0, 1'b0, 1'b0); step();
        drive(1'b1, 32'h22, 6'd2, 6'd0, 6'd0, 1'b0, 1'b0); step();
        drive(1'b1, 32'h33, 6'd3, 6'd0, 6'd0, 1'b0, 1'b0); step();
        check("ord_count3", 32'(count), 32'd3);
        check("ord_head", out_instr, 32'h11);
        drive(1'b0, 32'h0, '0, '0, '0, 1'b1, 1'b0);
        step();
        check("ord_second", out_instr, 32'h22);
        check("ord_seq1", 32'(out_seq), 32'd1);
        repeat (3) step();
        check("ord_empty", 32'(count), 32'd0);

        // full boundary
        repeat (9) begin drive_rand(1'b1, 1'b0, 1'b0); step(); end
        check("full_count", 32'(count), 32'd8);
        check("full_in_ready", 32'(in_ready), 32'd0);
        drive_rand(1'b1, 1'b1, 1'b0); step();
        check("full_after_deq_rdy", 32'(in_ready), 32'd1);
        drive_rand(1'b0, 1'b1, 1'b0);
        repeat (9) step();

        // steady state at count 4 with concurrent enq/deq
        repeat (4) begin drive_rand(1'b1, 1'b0, 1'b0); step(); end
        repeat (20) begin drive_rand(1'b1, 1'b1, 1'b0); step(); end
        check("steady_count", 32'(count), 32'd4);
        drive_rand(1'b0, 1'b1, 1'b0);
        repeat (4) step();

        // flush mid-stream with a simultaneous offer
        repeat (5) begin drive_rand(1'b1, 1'b0, 1'b0); step(); end
        drive_rand(1'b1, 1'b1, 1'b1); step();
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        drive_rand(1'b1, 1'b0, 1'b0); step();
        check("post_flush_seq", 32'(out_seq), 32'(8'(mseq - 1)));
        drive_rand(1'b0, 1'b1, 1'b0); step();

        // sequence wrap
        repeat (300) begin drive_rand(1'b1, 1'b1, 1'b0); step(); end
        drive_rand(1'b0, 1'b1, 1'b0);
        repeat (2) step();

        // random traffic with occasional flush and reset
        repeat (3000) begin
            drive_rand(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50),
                       1'($urandom_range(0, 99) < 3));
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        drive_rand(1'b0, 1'b1, 1'b0);
        repeat (DEPTH + 1) step();
        check("final_empty", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
